// File: rtl/ifid_queue.sv
// rtl/ifid_queue.sv - fetch-to-decode instruction queue
// Circular FIFO of {pc, inst, err} with flush and a fetch-fault fence.
module ifid_queue #(
   parameter int          DEPTH    = 2,
   parameter logic [15:0] NOP_INST = 16'h0800
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     if_valid,
   input  logic [15:0]              if_pc,
   input  logic [15:0]              if_inst,
   input  logic                     if_err,
   output logic                     if_ready,
   output logic                     id_valid,
   output logic [15:0]              id_pc,
   output logic [15:0]              id_pc_next,
   output logic [15:0]              id_inst,
   output logic                     id_err,
   input  logic                     id_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int            PW   = $clog2(DEPTH);
   localparam int            CW   = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [15:0]   mem_pc   [DEPTH];
   logic [15:0]   mem_inst [DEPTH];
   logic          mem_err  [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          fence;
   logic [15:0]   last_pc;
   logic          empty;
   logic          push;
   logic          pop;

   assign empty    = (count == '0);
   assign if_ready = (count != FULL) & ~fence;
   assign id_valid = ~empty;
   assign push     = if_valid & if_ready;
   assign pop      = id_valid & id_ready;

   // An empty queue shows the last PC handed to decode, so id_pc never glitches to garbage.
   assign id_pc      = empty ? last_pc  : mem_pc[rd_ptr];
   assign id_inst    = empty ? NOP_INST : mem_inst[rd_ptr];
   assign id_err     = empty ? 1'b0     : mem_err[rd_ptr];
   assign id_pc_next = id_pc + 16'd2;

   always_ff @(posedge clk) begin
      if (!rst && !flush && push) begin
         mem_pc[wr_ptr]   <= if_pc;
         mem_inst[wr_ptr] <= if_inst;
         mem_err[wr_ptr]  <= if_err;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         fence   <= 1'b0;
         last_pc <= 16'h0000;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (if_err)
               fence <= 1'b1;
         end
         if (pop) begin
            rd_ptr  <= rd_ptr + PW'(1);
            last_pc <= mem_pc[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_ifid_queue.sv
// tb/tb_ifid_queue.sv - directed bench for ifid_queue
// Queue-based reference model checked every cycle, plus literal checkpoints.
module tb_ifid_queue;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst, flush, if_valid, if_err, id_ready;
   logic [15:0] if_pc, if_inst;
   logic        if_ready, id_valid, id_err;
   logic [15:0] id_pc, id_pc_next, id_inst;
   logic [1:0]  count;

   ifid_queue #(.DEPTH(DEPTH), .NOP_INST(16'h0800)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_err(if_err),
      .if_ready(if_ready), .id_valid(id_valid), .id_pc(id_pc),
      .id_pc_next(id_pc_next), .id_inst(id_inst), .id_err(id_err),
      .id_ready(id_ready), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] inst;
      logic        err;
   } entry_t;

   entry_t      m_q[$];
   bit          m_fence   = 0;
   logic [15:0] m_last_pc = 16'h0000;
   bit          m_init    = 0;
   int          vectors   = 0;
   int          miscompares = 0;

   // Reference model: the queue's contract expressed directly on a list of entries.
   always @(posedge clk) begin
      bit     rdy, do_pop, do_push;
      entry_t e;
      if (rst || flush) begin
         m_q.delete();
         m_fence   = 0;
         m_last_pc = 16'h0000;
         if (rst) m_init = 1;
      end else begin
         rdy     = (m_q.size() < DEPTH) && !m_fence;
         do_pop  = (m_q.size() != 0) && id_ready;
         do_push = if_valid && rdy;
         if (do_pop) begin
            m_last_pc = m_q[0].pc;
            void'(m_q.pop_front());
         end
         if (do_push) begin
            e.pc = if_pc; e.inst = if_inst; e.err = if_err;
            m_q.push_back(e);
            if (if_err) m_fence = 1;
         end
      end
   end

   task automatic cmp(input string name, input int act, input int exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [15:0] e_pc;
      if (m_init) begin
         vectors++;
         e_pc = (m_q.size() != 0) ? m_q[0].pc : m_last_pc;
         cmp("count",      int'(count),      m_q.size());
         cmp("id_valid",   int'(id_valid),   int'(m_q.size() != 0));
         cmp("if_ready",   int'(if_ready),   int'((m_q.size() < DEPTH) && !m_fence));
         cmp("id_pc",      int'(id_pc),      int'(e_pc));
         cmp("id_pc_next", int'(id_pc_next), int'(16'(e_pc + 16'd2)));
         cmp("id_inst",    int'(id_inst),    (m_q.size() != 0) ? int'(m_q[0].inst) : 32'h0800);
         cmp("id_err",     int'(id_err),     (m_q.size() != 0) ? int'(m_q[0].err) : 0);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      cmp(name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input bit v, input logic [15:0] pc, input bit err, input bit rdy);
      if_valid = v;
      if_pc    = pc;
      if_inst  = pc ^ 16'h5A00;
      if_err   = err;
      id_ready = rdy;
   endtask

   initial begin
      rst = 1; flush = 0;
      drive(1, 16'h0100, 0, 0);
      tick(); tick();
      rst = 0;
      drive(0, 16'h0000, 0, 0);
      chk("rst_count",    int'(count),      0);
      chk("rst_id_valid", int'(id_valid),   0);
      chk("rst_id_inst",  int'(id_inst),    32'h0800);
      chk("rst_pc_next",  int'(id_pc_next), 32'h0002);
      chk("rst_if_ready", int'(if_ready),   1);

      // Streaming at one per cycle
      for (int i = 0; i < 4; i++) begin
         drive(1, 16'(2 * i), 0, 1);
         tick();
         chk("stream_pc",    int'(id_pc),    2 * i);
         chk("stream_count", int'(count),    1);
         chk("stream_rdy",   int'(if_ready), 1);
      end
      drive(0, 16'h0000, 0, 1);
      tick();
      chk("stream_last_pc", int'(id_pc),    6);
      chk("stream_empty",   int'(id_valid), 0);

      // Fill and stall
      drive(1, 16'h0010, 0, 0); tick();
      drive(1, 16'h0012, 0, 0); tick();
      drive(1, 16'h0014, 0, 0); tick();
      chk("fill_count", int'(count),    2);
      chk("fill_rdy",   int'(if_ready), 0);
      chk("fill_head",  int'(id_pc),    32'h10);
      chk("fill_inst",  int'(id_inst),  32'h5A10);
      drive(0, 16'h0000, 0, 1); tick();
      chk("drain_pc1", int'(id_pc), 32'h12);
      tick();
      chk("drain_count", int'(count), 0);

      // Fault fence
      drive(1, 16'h0020, 0, 0); tick();
      drive(1, 16'h0022, 1, 0); tick();
      drive(1, 16'h0024, 0, 1); tick();
      chk("fence_pc",    int'(id_pc),    32'h22);
      chk("fence_err",   int'(id_err),   1);
      chk("fence_count", int'(count),    1);
      chk("fence_rdy",   int'(if_ready), 0);
      tick(); tick(); tick();
      chk("fence_hold_count", int'(count),    0);
      chk("fence_hold_rdy",   int'(if_ready), 0);
      flush = 1; tick(); flush = 0;
      chk("fence_flush_rdy", int'(if_ready), 1);
      chk("fence_flush_pc",  int'(id_pc),    0);

      // Flush has priority over push and pop
      drive(1, 16'h0030, 0, 0); tick();
      flush = 1;
      drive(1, 16'h0032, 0, 1); tick();
      flush = 0;
      drive(0, 16'h0000, 0, 1);
      chk("flushp_count", int'(count),    0);
      chk("flushp_valid", int'(id_valid), 0);
      chk("flushp_rdy",   int'(if_ready), 1);
      tick();
      chk("flushp_absent", int'(count), 0);

      // PC wrap and pointer wrap
      drive(1, 16'hFFFE, 0, 0); tick();
      chk("wrap_pc",      int'(id_pc),      32'hFFFE);
      chk("wrap_pc_next", int'(id_pc_next), 32'h0000);
      for (int i = 0; i < 10; i++) begin
         drive(1, 16'(16'h0040 + 2 * i), 0, 1);
         tick();
      end
      chk("wrap_order", int'(id_pc), 32'h52);
      drive(0, 16'h0000, 0, 1); tick();

      // Mixed valid/ready pattern
      for (int i = 0; i < 16; i++) begin
         drive((i % 3) != 0, 16'(16'h0200 + 2 * i), 0, (i % 4) >= 2);
         tick();
      end

      // Reset mid-stream; push accepted on the cycle rst deasserts
      drive(1, 16'h0300, 0, 0); tick();
      rst = 1; drive(1, 16'h0302, 0, 0); tick();
      rst = 0; drive(1, 16'h0304, 0, 0); tick();
      drive(0, 16'h0000, 0, 0);
      chk("rst_mid_count", int'(count), 1);
      chk("rst_mid_pc",    int'(id_pc), 32'h0304);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ifid_queue.md
# ifid_queue

Instruction queue between the fetch stage and the decode stage. Captures each fetched `{pc, instruction, err}` triple in a small circular FIFO and presents the oldest entry to decode through a valid/ready handshake. This decouples fetch from decode stalls, so fetch keeps advancing until the queue fills. Also provides a flush for control-flow redirects and a fault fence that stops accepting new instructions once a fetch error has been queued.

## Interface
Parameters:
- `DEPTH`, 2: number of entries; power of two, ≥ 2.
- `NOP_INST`, 16'h0800: instruction word driven on `id_inst` when the queue is empty.

Ports:
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `flush`  in  1  — discard all entries and clear the fault fence.
- `if_valid`  in  1  — fetch presents an entry this cycle.
- `if_pc`  in  16  — PC of the fetched instruction.
- `if_inst`  in  16  — fetched instruction word.
- `if_err`  in  1  — instruction-memory error for this fetch.
- `if_ready`  out  1  — the queue accepts a push this cycle.
- `id_valid`  out  1  — the head entry is valid.
- `id_pc`  out  16  — PC of the head entry.
- `id_pc_next`  out  16  — `id_pc + 2`, mod 2^16.
- `id_inst`  out  16  — instruction word of the head entry.
- `id_err`  out  1  — error flag of the head entry.
- `id_ready`  in  1  — decode consumes the head entry this cycle.
- `count`  out  $clog2(DEPTH)+1  — current occupancy.

## Operation
- **Storage:**
  - `DEPTH` entries of `{pc[15:0], inst[15:0], err}`.
  - Read and write pointers are `$clog2(DEPTH)` bits wide and wrap modulo `DEPTH`.
  - `count` is an explicit register.
- **Fence:** `fence` is an internal register.
- **Push condition:** `push = if_valid & if_ready`.
  - `if_ready = (count != DEPTH) & ~fence`.
  - `if_ready` is a function of registered state only; it never depends on `id_ready`.
- **Pop condition:** `pop = id_valid & id_ready`.
- **Push and pop in the same cycle:**
  - Both pointers advance and `count` is unchanged.
  - This is legal at any occupancy where push is permitted (i.e. `count < DEPTH`).
- **Empty / full boundaries:**
  - When `count == 0`, `id_ready` has no effect.
  - When `count == DEPTH`, `if_valid` is ignored and fetch must hold its entry.
- **Empty-queue output values:**
  - `id_valid = 0`, `id_inst = NOP_INST`, `id_err = 0`.
  - `id_pc` holds the last popped PC (0 after reset or after a flush).
- **Fault fence:**
  - Set on the push of any entry whose `if_err = 1`.
  - While set, `if_ready = 0`; entries already queued, including the erroneous one, still drain to decode normally.
  - Cleared only by `flush` or `rst`.
- **Flush:**
  - Next cycle: `count = 0`, both pointers = 0, `fence = 0`, `id_pc = 0`.
  - Flush has priority over a push or pop in the same cycle; neither takes effect, and fetch must re-present the entry after the redirect.
- **`id_pc_next`:** combinational `id_pc + 16'd2`, truncated to 16 bits (16'hFFFE → 16'h0000).
- **Reset** (synchronous, highest priority), values on the next edge:
  - `count = 0`, `fence = 0`, pointers = 0.
  - `id_valid = 0`, `id_pc = 0`, `id_pc_next = 2`, `id_inst = NOP_INST`, `id_err = 0`.
  - `if_ready = 1`.
  - Storage contents are don't-care.

## Timing
- **Latency:** an entry pushed at edge N appears on the `id_*` outputs after edge N (one cycle). There is no same-cycle bypass from `if_*` to `id_*`.
- **Throughput:** one instruction per cycle sustained when `id_ready = 1` and `DEPTH ≥ 2`.
- **Output timing:**
  - `id_*` and `if_ready` are driven from registers or from a register-indexed storage read.
  - No combinational path exists from any input to `if_ready`.
- **Handshake stability:** once asserted, `id_valid` stays high with the `id_*` payload stable until popped, flushed, or reset.
- **Reset mid-operation:** reset asserted during a stream drops all entries. The first push after reset is accepted on the cycle `rst` deasserts.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `if_valid = 1` → `count = 0`, `id_valid = 0`, `id_inst = 16'h0800`, `id_pc_next = 16'h0002`, `if_ready = 1`.
- **Streaming:** push PCs 0, 2, 4, 6 on consecutive cycles with `id_ready = 1` → `id_pc` = 0, 2, 4, 6 on cycles 1–4; `count` stays at 1; `if_ready` stays 1.
- **Fill and stall:** `id_ready = 0`, push PCs 0x10, 0x12, 0x14 → the third push is refused; `count = 2` and `if_ready = 0`. Raise `id_ready` → pops in order 0x10, 0x12.
- **Fault fence:** push 0x20 (err=0), then 0x22 (err=1), then 0x24 → 0x24 is refused. Decode sees 0x20 then 0x22 with `id_err = 1`, and `if_ready` stays 0 until `flush`.
- **Flush priority:** with `count = 1`, assert `flush`, `if_valid`, and `id_ready` together → next cycle `count = 0`, `id_valid = 0`, `if_ready = 1`, and the pushed entry is absent.
- **Wrap-around:** push `if_pc = 16'hFFFE` → `id_pc_next = 16'h0000`. Run 10 push/pop cycles with `DEPTH = 2` → the pointers wrap and FIFO order is preserved.
